// File: rtl/ws2812b_pkg.sv
// Shared types and timing defaults for the WS2812B receive path.
// No logic, so there is no latency.
// No flow control here; the FSM and its error codes are defined for the receiver.
package ws2812b_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        SYNC_WAIT,
        IDLE,
        HIGH,
        LOW,
        ERR
    } state_t;

    // err_code values, valid while err is high
    localparam logic [1:0] ERR_LONG_HIGH = 2'b01;
    localparam logic [1:0] ERR_PARTIAL   = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

    // 12 MHz timing defaults, shared with the panel transmitter
    localparam int DEF_MIN_HIGH     = 2;
    localparam int DEF_BIT_THRESH   = 7;
    localparam int DEF_MAX_HIGH     = 24;
    localparam int DEF_RESET_CYCLES = 600;
    localparam int DEF_NUM_PIXELS   = 64;

    localparam int PIXEL_BITS = 24;

endpackage

// File: rtl/ws2812b_rx_pulse_meter.sv
// Synchronizes din and measures the high and low run lengths of the synced line.
// Latency: din to din_s is 2 clks; rise/fall/high_width/low_timeout are flop-derived.
// No backpressure: the line is free-running and every cycle is measured.
// Ports: clk, rst (sync, active-high), din (async line);
//        rise/fall = edges of din_s; high_width = completed high run length, valid at fall;
//        low_timeout = one-cycle pulse on the RESET_CYCLES-th consecutive low cycle.
module ws2812b_rx_pulse_meter #(
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600,
    parameter int HW_W         = $clog2(MAX_HIGH + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    output logic            rise,
    output logic            fall,
    output logic [HW_W-1:0] high_width,
    output logic            low_timeout
);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    logic            sync1;
    logic            din_s;
    logic            din_d;
    logic [HW_W-1:0] hcnt;
    logic [LW-1:0]   lcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
            din_d <= din_s;
            // hcnt holds the number of high cycles before the current one,
            // so on the fall cycle it equals the full pulse width.
            if (!din_s)
                hcnt <= '0;
            else if (hcnt != HW_W'(MAX_HIGH + 1))
                hcnt <= hcnt + 1'b1;
            // Saturating at RESET_CYCLES makes low_timeout fire once per gap.
            if (din_s)
                lcnt <= '0;
            else if (lcnt != LW'(RESET_CYCLES))
                lcnt <= lcnt + 1'b1;
        end
    end

    assign rise        = din_s & ~din_d;
    assign fall        = ~din_s & din_d;
    assign high_width  = hcnt;
    assign low_timeout = ~din_s & (lcnt == LW'(RESET_CYCLES - 1));

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes pulse widths into indexed 24-bit GRB pixels and frame latches.
// Latency: strobes are registered, 1 clk after the decision cycle (3 clks after the pin).
// No backpressure: pixel/frame/err strobes are single-cycle and must be taken when seen.
// Ports: clk, rst (sync, active-high), din (async line); pixel_data/pixel_valid/pixel_index,
//        frame_done/frame_pixels, err/err_code (01 long high, 10 partial at latch, 11 overflow).
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int MAX_HIGH     = DEF_MAX_HIGH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [5:0]  pixel_index,
    output logic        frame_done,
    output logic [6:0]  frame_pixels,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int HW_W = $clog2(MAX_HIGH + 2);

    logic            rise;
    logic            fall;
    logic            low_timeout;
    logic [HW_W-1:0] high_width;

    state_t      state, state_n;
    state_t      ret_state, ret_state_n;   // where a glitch returns to
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [23:0] shreg, shreg_n;
    logic [6:0]  pix_cnt, pix_cnt_n;
    logic        pix_emit;
    logic        frame_emit;
    logic        err_emit;
    logic [1:0]  err_code_n;

    ws2812b_rx_pulse_meter #(
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES),
        .HW_W         (HW_W)
    ) u_meter (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .rise        (rise),
        .fall        (fall),
        .high_width  (high_width),
        .low_timeout (low_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC_WAIT;
            ret_state    <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            pix_cnt      <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            state       <= state_n;
            ret_state   <= ret_state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            pix_cnt     <= pix_cnt_n;
            pixel_valid <= pix_emit;
            frame_done  <= frame_emit;
            err         <= err_emit;
            err_code    <= err_emit ? err_code_n : 2'b00;
            if (pix_emit) begin
                pixel_data  <= shreg;
                pixel_index <= pix_cnt[5:0];
            end
            if (frame_emit)
                frame_pixels <= pix_cnt;
        end
    end

    always_comb begin
        state_n     = state;
        ret_state_n = ret_state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        pix_cnt_n   = pix_cnt;
        pix_emit    = 1'b0;
        frame_emit  = 1'b0;
        err_emit    = 1'b0;
        err_code_n  = 2'b00;

        case (state)
            SYNC_WAIT: begin
                if (low_timeout)
                    state_n = IDLE;
            end
            IDLE: begin
                bit_cnt_n = '0;
                shreg_n   = '0;
                pix_cnt_n = '0;
                if (rise) begin
                    state_n     = HIGH;
                    ret_state_n = IDLE;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (high_width < HW_W'(MIN_HIGH)) begin
                        state_n = ret_state;
                    end else begin
                        shreg_n   = {shreg[22:0], (high_width >= HW_W'(BIT_THRESH))};
                        bit_cnt_n = bit_cnt + 5'd1;
                        state_n   = LOW;
                    end
                end else if (high_width == HW_W'(MAX_HIGH)) begin
                    // Current cycle is high cycle MAX_HIGH+1.
                    err_emit   = 1'b1;
                    err_code_n = ERR_LONG_HIGH;
                    bit_cnt_n  = '0;
                    shreg_n    = '0;
                    state_n    = ERR;
                end
            end
            LOW: begin
                // A full word lands here the cycle after its last fall.
                if (bit_cnt == 5'(PIXEL_BITS)) begin
                    bit_cnt_n = '0;
                    if (pix_cnt < 7'(NUM_PIXELS)) begin
                        pix_emit  = 1'b1;
                        pix_cnt_n = pix_cnt + 7'd1;
                    end else begin
                        err_emit   = 1'b1;
                        err_code_n = ERR_OVERFLOW;
                    end
                end
                if (rise) begin
                    state_n     = HIGH;
                    ret_state_n = LOW;
                end else if (low_timeout) begin
                    frame_emit = 1'b1;
                    if (bit_cnt != '0) begin
                        err_emit   = 1'b1;
                        err_code_n = ERR_PARTIAL;
                    end
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            ERR: begin
                if (low_timeout)
                    state_n = IDLE;
            end
            default: state_n = SYNC_WAIT;
        endcase
    end

endmodule
